// File: rtl/opendap_ap_pkg.sv
// Shared types and sizes for the SW-DP access-port multiplexer.
package opendap_ap_pkg;

    localparam int AP_ADDR_W = 6;
    localparam int AP_DATA_W = 32;
    localparam int AP_SEL_W  = 8;
    localparam int N_AP_MAX  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } ap_state_e;

endpackage

// File: rtl/opendap_onehot_rdmux.sv
// Selects read data, ready and error of the addressed AP; zero when idx is
// outside the implemented range.
module opendap_onehot_rdmux
    import opendap_ap_pkg::*;
#(
    parameter int N_AP = 2
) (
    input  logic [AP_SEL_W-1:0]       idx,
    input  logic [AP_DATA_W*N_AP-1:0] dn_rdata,
    input  logic [N_AP-1:0]           dn_rdy,
    input  logic [N_AP-1:0]           dn_err,
    output logic [AP_DATA_W-1:0]      sel_rdata,
    output logic                      sel_rdy,
    output logic                      sel_err
);

    // Pick the single AP whose number matches idx.
    always_comb begin
        sel_rdata = '0;
        sel_rdy   = 1'b0;
        sel_err   = 1'b0;
        for (int k = 0; k < N_AP; k++) begin
            if (idx == AP_SEL_W'(k)) begin
                sel_rdata = dn_rdata[AP_DATA_W*k +: AP_DATA_W];
                sel_rdy   = dn_rdy[k];
                sel_err   = dn_err[k];
            end
        end
    end

endmodule

// File: rtl/opendap_ap_mux.sv
// Routes the SW-DP's single AP port to N_AP downstream access ports.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no transfer in flight, up_rdy high, accepts a new strobe
// ST_ISSUE | one-cycle strobe to the selected AP (none if unimplemented)
// ST_WAIT  | waiting for dn_rdy of the selected AP; only abort escapes
module opendap_ap_mux
    import opendap_ap_pkg::*;
#(
    parameter int N_AP = 2
) (
    input  logic                      swclk,
    input  logic                      rst,
    input  logic [7:0]                up_sel,
    input  logic [5:0]                up_addr,
    input  logic [31:0]               up_wdata,
    input  logic                      up_wen,
    input  logic                      up_ren,
    input  logic                      up_abort,
    output logic [31:0]               up_rdata,
    output logic                      up_rdy,
    output logic                      up_err,
    output logic [5:0]                dn_addr,
    output logic [31:0]               dn_wdata,
    output logic [N_AP-1:0]           dn_wen,
    output logic [N_AP-1:0]           dn_ren,
    output logic [N_AP-1:0]           dn_abort,
    input  logic [32*N_AP-1:0]        dn_rdata,
    input  logic [N_AP-1:0]           dn_rdy,
    input  logic [N_AP-1:0]           dn_err
);

    localparam logic [AP_SEL_W-1:0] N_AP_SEL = AP_SEL_W'(N_AP);

    ap_state_e              state_q;
    logic [AP_SEL_W-1:0]    idx_q;
    logic                   dir_q;
    logic [AP_DATA_W-1:0]   rdata_q;
    logic                   err_q;

    logic                   idx_hit;
    logic                   issue_go;
    logic [AP_DATA_W-1:0]   sel_rdata;
    logic                   sel_rdy;
    logic                   sel_err;

    assign idx_hit  = (idx_q < N_AP_SEL);
    // Abort and reset both kill the strobe in the same cycle they appear.
    assign issue_go = (state_q == ST_ISSUE) && idx_hit && !up_abort && !rst;

    opendap_onehot_rdmux #(
        .N_AP (N_AP)
    ) u_rdmux (
        .idx       (idx_q),
        .dn_rdata  (dn_rdata),
        .dn_rdy    (dn_rdy),
        .dn_err    (dn_err),
        .sel_rdata (sel_rdata),
        .sel_rdy   (sel_rdy),
        .sel_err   (sel_err)
    );

    // Transfer sequencing, request capture and held response.
    always_ff @(posedge swclk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            dir_q    <= 1'b0;
            dn_addr  <= '0;
            dn_wdata <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (up_abort) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    err_q <= 1'b0;
                    if (up_wen || up_ren) begin
                        idx_q    <= up_sel;
                        dir_q    <= up_wen;
                        dn_addr  <= up_addr;
                        dn_wdata <= up_wdata;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (idx_hit) begin
                        state_q <= ST_WAIT;
                    end else begin
                        // Unimplemented AP: reads return zero, no error.
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (sel_rdy) begin
                        if (!dir_q) begin
                            rdata_q <= sel_rdata;
                        end
                        err_q   <= sel_err;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // One-hot strobe to the selected AP during the issue cycle only.
    always_comb begin
        dn_wen = '0;
        dn_ren = '0;
        for (int k = 0; k < N_AP; k++) begin
            if (issue_go && (idx_q == AP_SEL_W'(k))) begin
                dn_wen[k] = dir_q;
                dn_ren[k] = !dir_q;
            end
        end
    end

    assign dn_abort = {N_AP{up_abort}};
    assign up_rdy   = rst || (state_q == ST_IDLE);
    assign up_err   = err_q && !rst;
    assign up_rdata = rdata_q;

endmodule
